// File: rtl/l0_tile_scheduler_pkg.sv
// Shared definitions for the L0 tile scheduler.
//   state_t           : scheduler FSM states
//   STAT_*            : 2-bit buffer status codes reported per L0 buffer
//   SEL_*             : 2-bit buffer-select codes used on mem_sel / l0_wr_sel
//   calc_l0_steps     : compute steps per tile (weight x output beats plus drain)
//   calc_total_steps  : compute steps per layer
package l0_tile_scheduler_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ_W,
    ST_BEAT_W,
    ST_REQ_I,
    ST_BEAT_I,
    ST_REQ_O,
    ST_BEAT_O,
    ST_COMPUTE,
    ST_FIN
  } state_t;

  localparam logic [1:0] STAT_IDLE    = 2'b00;
  localparam logic [1:0] STAT_LOADING = 2'b01;
  localparam logic [1:0] STAT_LOADED  = 2'b10;
  localparam logic [1:0] STAT_DONE    = 2'b11;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_WEIGHT = 2'b01;
  localparam logic [1:0] SEL_INPUT  = 2'b10;
  localparam logic [1:0] SEL_OUTPUT = 2'b11;

  function automatic int calc_l0_steps(input int weight_nums, input int output_nums,
                                       input int pipeline_tail);
    return weight_nums * output_nums + pipeline_tail;
  endfunction

  function automatic int calc_total_steps(input int tile_nums, input int l0_steps);
    return tile_nums * l0_steps;
  endfunction

endpackage

// File: rtl/l0_beat_counter.sv
// Beat counter shared by the weight, input and output loads.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : return the count to zero (wins over inc)
//   inc        : one beat accepted this cycle
//   len        : beat count of the current load
//   count      : beats accepted so far in the current load
//   last       : count is on the final beat of the load (count == len-1)
module l0_beat_counter
  import l0_tile_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] len,
  output logic [3:0] count,
  output logic       last
);

  logic [3:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 4'd0;
    end else if (clr) begin
      count_reg <= 4'd0;
    end else if (inc) begin
      count_reg <= count_reg + 4'd1;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == (len - 4'd1));

endmodule

// File: rtl/l0_tile_scheduler.sv
// L0 tile scheduler: for each tile, fetches weight, input and output beats
// into the L0 buffers, then strobes the PE array for L0_STEPS cycles; after
// TILE_NUMS tiles it pulses done.
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : layer start pulse (honoured only in IDLE)
//   mem_req/mem_sel/mem_len  : memory request, held until mem_gnt
//   mem_gnt, mem_rvalid      : request accept, returned beat
//   l0_wr_en/_sel/_addr      : write strobe into the selected L0 buffer
//   compute_en, l0_step, total_step : PE advance strobe and step counters
//   weight/input/output_status      : per-buffer status codes
//   busy, done               : not-idle flag, layer-complete pulse
module l0_tile_scheduler
  import l0_tile_scheduler_pkg::*;
#(
  parameter int L0_WEIGHT_NUMS = 2,
  parameter int L0_INPUT_NUMS  = 8,
  parameter int L0_OUTPUT_NUMS = 8,
  parameter int PIPELINE_TAIL  = 3,
  parameter int TILE_NUMS      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       mem_req,
  output logic [1:0] mem_sel,
  output logic [3:0] mem_len,
  input  logic       mem_gnt,
  input  logic       mem_rvalid,
  output logic       l0_wr_en,
  output logic [1:0] l0_wr_sel,
  output logic [3:0] l0_wr_addr,
  output logic       compute_en,
  output logic [4:0] l0_step,
  output logic [6:0] total_step,
  output logic [1:0] weight_status,
  output logic [1:0] input_status,
  output logic [1:0] output_status,
  output logic       busy,
  output logic       done
);

  localparam int L0_STEPS = calc_l0_steps(L0_WEIGHT_NUMS, L0_OUTPUT_NUMS, PIPELINE_TAIL);
  localparam int TOTAL_STEPS = calc_total_steps(TILE_NUMS, L0_STEPS);
  localparam logic [4:0] L0_LAST   = 5'(L0_STEPS - 1);
  localparam logic [3:0] TILE_LAST = 4'(TILE_NUMS - 1);

  state_t     state_reg, state_next;
  logic [4:0] l0_step_reg;
  logic [6:0] total_step_reg;
  logic [3:0] tile_reg;
  logic [1:0] w_stat_reg, i_stat_reg, o_stat_reg;

  logic       is_req, is_beat;
  logic [1:0] cur_sel;
  logic [3:0] cur_len;
  logic       beat_fire, beat_last, load_done;
  logic [3:0] beat_count;
  logic       step_wrap, final_tile;

  // Buffer selection and length decoded from the state; shared by REQ and BEAT.
  always_comb begin
    cur_sel = SEL_NONE;
    cur_len = 4'd0;
    is_req  = 1'b0;
    is_beat = 1'b0;
    case (state_reg)
      ST_REQ_W, ST_BEAT_W: begin cur_sel = SEL_WEIGHT; cur_len = 4'(L0_WEIGHT_NUMS); end
      ST_REQ_I, ST_BEAT_I: begin cur_sel = SEL_INPUT;  cur_len = 4'(L0_INPUT_NUMS);  end
      ST_REQ_O, ST_BEAT_O: begin cur_sel = SEL_OUTPUT; cur_len = 4'(L0_OUTPUT_NUMS); end
      default: ;
    endcase
    is_req  = (state_reg == ST_REQ_W)  || (state_reg == ST_REQ_I)  || (state_reg == ST_REQ_O);
    is_beat = (state_reg == ST_BEAT_W) || (state_reg == ST_BEAT_I) || (state_reg == ST_BEAT_O);
  end

  // Beats are only accepted in BEAT states, so a beat coincident with a grant is dropped.
  assign beat_fire  = is_beat && mem_rvalid;
  assign load_done  = beat_fire && beat_last;
  assign step_wrap  = (state_reg == ST_COMPUTE) && (l0_step_reg == L0_LAST);
  assign final_tile = (tile_reg == TILE_LAST);

  l0_beat_counter u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_done),
    .inc   (beat_fire),
    .len   (cur_len),
    .count (beat_count),
    .last  (beat_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start)     state_next = ST_REQ_W;
      ST_REQ_W:   if (mem_gnt)   state_next = ST_BEAT_W;
      ST_BEAT_W:  if (load_done) state_next = ST_REQ_I;
      ST_REQ_I:   if (mem_gnt)   state_next = ST_BEAT_I;
      ST_BEAT_I:  if (load_done) state_next = ST_REQ_O;
      ST_REQ_O:   if (mem_gnt)   state_next = ST_BEAT_O;
      ST_BEAT_O:  if (load_done) state_next = ST_COMPUTE;
      ST_COMPUTE: if (step_wrap) state_next = final_tile ? ST_FIN : ST_REQ_W;
      ST_FIN:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Step, tile and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l0_step_reg    <= 5'd0;
      total_step_reg <= 7'd0;
      tile_reg       <= 4'd0;
      w_stat_reg     <= STAT_IDLE;
      i_stat_reg     <= STAT_IDLE;
      o_stat_reg     <= STAT_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (start) begin
          l0_step_reg    <= 5'd0;
          total_step_reg <= 7'd0;
          tile_reg       <= 4'd0;
          w_stat_reg     <= STAT_LOADING;
          i_stat_reg     <= STAT_LOADING;
          o_stat_reg     <= STAT_LOADING;
        end
        ST_BEAT_W: if (load_done) w_stat_reg <= STAT_LOADED;
        ST_BEAT_I: if (load_done) i_stat_reg <= STAT_LOADED;
        ST_BEAT_O: if (load_done) o_stat_reg <= STAT_LOADED;
        ST_COMPUTE: begin
          if (!step_wrap) begin
            l0_step_reg    <= l0_step_reg + 5'd1;
            total_step_reg <= total_step_reg + 7'd1;
          end else if (final_tile) begin
            // Layer finished: counters park at zero, statuses report done.
            l0_step_reg    <= 5'd0;
            total_step_reg <= 7'd0;
            w_stat_reg     <= STAT_DONE;
            i_stat_reg     <= STAT_DONE;
            o_stat_reg     <= STAT_DONE;
          end else begin
            l0_step_reg    <= 5'd0;
            total_step_reg <= total_step_reg + 7'd1;
            tile_reg       <= tile_reg + 4'd1;
            w_stat_reg     <= STAT_LOADING;
            i_stat_reg     <= STAT_LOADING;
            o_stat_reg     <= STAT_LOADING;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    mem_req       = is_req;
    mem_sel       = is_req ? cur_sel : SEL_NONE;
    mem_len       = is_req ? cur_len : 4'd0;
    l0_wr_en      = beat_fire;
    l0_wr_sel     = is_beat ? cur_sel : SEL_NONE;
    l0_wr_addr    = is_beat ? beat_count : 4'd0;
    compute_en    = (state_reg == ST_COMPUTE);
    l0_step       = l0_step_reg;
    total_step    = total_step_reg;
    weight_status = w_stat_reg;
    input_status  = i_stat_reg;
    output_status = o_stat_reg;
    busy          = (state_reg != ST_IDLE);
    done          = (state_reg == ST_FIN);
  end

endmodule

// File: tb/tb_l0_tile_scheduler.sv
// Directed bench for l0_tile_scheduler: drives whole layers through a small
// memory responder and checks writes, compute steps, statuses and done.
module tb_l0_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mem_gnt = 1'b0;
  logic       mem_rvalid = 1'b0;
  logic       mem_req;
  logic [1:0] mem_sel;
  logic [3:0] mem_len;
  logic       l0_wr_en;
  logic [1:0] l0_wr_sel;
  logic [3:0] l0_wr_addr;
  logic       compute_en;
  logic [4:0] l0_step;
  logic [6:0] total_step;
  logic [1:0] weight_status, input_status, output_status;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  l0_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_len(mem_len),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .l0_wr_en(l0_wr_en), .l0_wr_sel(l0_wr_sel), .l0_wr_addr(l0_wr_addr),
    .compute_en(compute_en), .l0_step(l0_step), .total_step(total_step),
    .weight_status(weight_status), .input_status(input_status),
    .output_status(output_status), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [34:0] all_outs = {mem_req, mem_sel, mem_len, l0_wr_en, l0_wr_sel, l0_wr_addr,
                          compute_en, l0_step, total_step, weight_status, input_status,
                          output_status, busy, done};

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (all_outs !== 35'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 0", all_outs);
    end
    $display("test_reset: outputs=%h", all_outs);
  endtask

  // Runs one layer. gnt_delay: cycles each request waits before grant.
  // alt_rv: beats every other cycle. stray: rvalid with the weight grant and
  // inside REQ_I. start_beat_i/start_fin: spurious start pulses.
  // abort_tile>=0: assert reset at that tile/l0_step during compute.
  task automatic run_layer(input string name, input int gnt_delay, input bit alt_rv,
                           input bit stray, input bit start_beat_i, input bit start_fin,
                           input int abort_tile, input int abort_step);
    logic [1:0] exp_sel [3] = '{2'b01, 2'b10, 2'b11};
    int exp_len [3] = '{2, 8, 8};
    int wr_cnt [3] = '{0, 0, 0};
    int req_wait = 0, beats_left = 0, req_idx = 0, burst_idx = 0, exp_addr = 0;
    int tile = 0, comp_cnt = 0, done_cnt = 0, max_ts = 0;
    bit in_burst = 0, phase = 0, stray_now = 0, sb_done = 0, aborted = 0;
    bit prev_in_last = 0, prev_out_last = 0, prev_wrap = 0, fin_next = 0;
    for (int cyc = 0; cyc < 4000 && done_cnt == 0 && !aborted; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (start_fin && fin_next);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      stray_now = 0;
      if (mem_req) begin
        if (req_wait >= gnt_delay) begin
          mem_gnt = 1'b1;
          req_wait = 0;
          checks++;
          if (mem_sel !== exp_sel[req_idx] || mem_len !== 4'(exp_len[req_idx])) begin
            errors++;
            $display("FAIL %s req: sel=%b len=%0d expected sel=%b len=%0d", name,
                     mem_sel, mem_len, exp_sel[req_idx], exp_len[req_idx]);
          end
          if (stray && req_idx == 0) begin
            mem_rvalid = 1'b1;
            stray_now = 1;
          end
          burst_idx = req_idx;
          beats_left = exp_len[req_idx];
          exp_addr = 0;
          phase = 0;
          in_burst = 1;
          req_idx = (req_idx + 1) % 3;
        end else begin
          if (stray && req_idx == 1 && req_wait == 1) begin
            mem_rvalid = 1'b1;
            stray_now = 1;
          end
          req_wait++;
        end
      end else if (in_burst) begin
        if (!alt_rv || phase) begin
          mem_rvalid = 1'b1;
          beats_left--;
          if (beats_left == 0) in_burst = 0;
        end
        phase = !phase;
        if (start_beat_i && !sb_done && burst_idx == 1 && beats_left == 4) begin
          start = 1'b1;
          sb_done = 1;
        end
      end
      #1;
      if (mem_rvalid && !stray_now) begin
        checks++;
        if (l0_wr_en !== 1'b1 || l0_wr_sel !== exp_sel[burst_idx] ||
            l0_wr_addr !== 4'(exp_addr)) begin
          errors++;
          $display("FAIL %s write: en=%b sel=%b addr=%0d expected en=1 sel=%b addr=%0d",
                   name, l0_wr_en, l0_wr_sel, l0_wr_addr, exp_sel[burst_idx], exp_addr);
        end
        if (l0_wr_en === 1'b1) wr_cnt[burst_idx]++;
        exp_addr++;
      end else if (l0_wr_en !== 1'b0 || stray_now) begin
        checks++;
        if (l0_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL %s spurious_write: en=%b expected 0 (stray=%0d)", name,
                   l0_wr_en, stray_now);
        end
      end
      if (prev_in_last) begin
        checks++;
        if (input_status !== 2'b10) begin
          errors++;
          $display("FAIL %s input_loaded: status=%b expected 10", name, input_status);
        end
      end
      if (prev_out_last) begin
        checks++;
        if (compute_en !== 1'b1 || l0_step !== 5'd0) begin
          errors++;
          $display("FAIL %s compute_latency: en=%b l0_step=%0d expected en=1 step=0",
                   name, compute_en, l0_step);
        end
      end
      if (prev_wrap) begin
        checks++;
        if (mem_req !== 1'b1 || mem_sel !== 2'b01 || l0_step !== 5'd0 ||
            total_step !== 7'(tile * 19) ||
            {weight_status, input_status, output_status} !== 6'b010101) begin
          errors++;
          $display("FAIL %s tile_boundary: req=%b sel=%b step=%0d total=%0d stat=%b%b%b expected 1 01 0 %0d 010101",
                   name, mem_req, mem_sel, l0_step, total_step, weight_status,
                   input_status, output_status, tile * 19);
        end
      end
      prev_in_last  = mem_rvalid && !stray_now && burst_idx == 1 && exp_addr == 8;
      prev_out_last = mem_rvalid && !stray_now && burst_idx == 2 && exp_addr == 8;
      prev_wrap = 0;
      fin_next = 0;
      if (compute_en === 1'b1) begin
        comp_cnt++;
        if (int'(total_step) > max_ts) max_ts = int'(total_step);
        checks++;
        if (total_step !== 7'(tile * 19) + 7'(l0_step)) begin
          errors++;
          $display("FAIL %s total_step: got %0d expected %0d", name, total_step,
                   tile * 19 + int'(l0_step));
        end
        if (tile == abort_tile && int'(l0_step) == abort_step) begin
          rst_n = 1'b0;
          #1;
          checks++;
          if (all_outs !== 35'd0) begin
            errors++;
            $display("FAIL %s abort_reset: outputs=%h expected 0", name, all_outs);
          end
          aborted = 1;
        end else if (l0_step == 5'd18) begin
          if (tile < 3) begin
            prev_wrap = 1;
            tile++;
          end else begin
            fin_next = 1;
          end
        end
      end
      if (done === 1'b1) done_cnt++;
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (aborted) begin
      start = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (all_outs !== 35'd0 || done_cnt != 0) begin
        errors++;
        $display("FAIL %s abort_hold: outputs=%h done=%0d expected 0 0", name, all_outs,
                 done_cnt);
      end
      rst_n = 1'b1;
      $display("%s: aborted at tile %0d step %0d, computes=%0d", name, tile, abort_step,
               comp_cnt);
    end else begin
      checks++;
      if (done_cnt != 1 || wr_cnt[0] != 8 || wr_cnt[1] != 32 || wr_cnt[2] != 32 ||
          comp_cnt != 76 || max_ts != 75) begin
        errors++;
        $display("FAIL %s layer_totals: done=%0d wr=%0d/%0d/%0d comp=%0d max_ts=%0d expected 1 8/32/32 76 75",
                 name, done_cnt, wr_cnt[0], wr_cnt[1], wr_cnt[2], comp_cnt, max_ts);
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 ||
          {weight_status, input_status, output_status} !== 6'b111111) begin
        errors++;
        $display("FAIL %s post_done: busy=%b done=%b stat=%b%b%b expected 0 0 111111",
                 name, busy, done, weight_status, input_status, output_status);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL %s stay_idle: busy=%b req=%b expected 0 0", name, busy, mem_req);
      end
      $display("%s: done=%0d writes=%0d/%0d/%0d computes=%0d max_total=%0d", name,
               done_cnt, wr_cnt[0], wr_cnt[1], wr_cnt[2], comp_cnt, max_ts);
    end
  endtask

  task automatic test_full_layer();
    run_layer("full_layer", 5, 0, 0, 0, 0, -1, 0);
  endtask

  task automatic test_reset_mid_compute();
    run_layer("reset_mid_compute", 0, 0, 0, 0, 0, 2, 7);
    run_layer("restart_after_reset", 1, 0, 0, 0, 0, -1, 0);
  endtask

  task automatic test_stray_alt_rvalid();
    run_layer("stray_alt_rvalid", 3, 1, 1, 0, 0, -1, 0);
  endtask

  task automatic test_start_ignored();
    run_layer("start_ignored", 2, 0, 0, 1, 1, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_layer("back_to_back", 0, 0, 0, 0, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_reset_mid_compute();
    test_stray_alt_rvalid();
    test_start_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
